// File: rtl/eq_serial_ctrl.sv
// -----------------------------------------------------------------------------
// eq_serial_ctrl
//   Bit-serial equality comparator. An accepted start latches operands a and b,
//   then one bit pair is compared per cycle, LSB first. The result (eq, plus
//   the index of the lowest mismatching bit) is presented with a one-cycle
//   done pulse and held until the next result is produced.
//
// Parameters
//   W          : compared word width in bits (2..64)
//   EARLY_EXIT : 1 = stop at first mismatching bit, 0 = always scan all W bits
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   start  in   compare request, sampled only while ready=1
//   a, b   in   operands, captured on accepted start
//   ready  out  idle, able to accept start
//   busy   out  compare in progress
//   done   out  one-cycle pulse, eq/mm_idx valid
//   eq     out  1 = captured operands equal
//   mm_idx out  index of lowest mismatching bit (0 when equal)
// -----------------------------------------------------------------------------
module eq_serial_ctrl #(
  parameter int W          = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 eq,
  output logic [$clog2(W)-1:0] mm_idx
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Single-bit equality written as an explicit XNOR sum of products.
  function automatic logic bit_eq(input logic ai, input logic bi);
    return (~ai & ~bi) | (ai & bi);
  endfunction

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [CW-1:0]   r_cnt;
  logic            r_acc;
  logic [CW-1:0]   r_mm;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_eq;
  logic [CW-1:0]   r_mm_idx;

  logic            w_bit_eq;
  logic            w_acc_next;
  logic [CW-1:0]   w_mm_next;
  logic            w_exit;

  // Current bit pair under evaluation and the values the accumulators take
  // after it. A mismatch index is only recorded while the accumulator is
  // still 1, i.e. on the first mismatch of this compare.
  assign w_bit_eq   = bit_eq(r_a[r_cnt], r_b[r_cnt]);
  assign w_acc_next = r_acc & w_bit_eq;
  assign w_mm_next  = (r_acc && !w_bit_eq) ? r_cnt : r_mm;
  assign w_exit     = (r_cnt == LAST_IDX) || ((EARLY_EXIT != 0) && !w_bit_eq);

  // Control FSM with registered status outputs and result hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_acc    <= 1'b0;
      r_mm     <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_eq     <= 1'b0;
      r_mm_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= '0;
            r_acc   <= 1'b1;
            r_mm    <= '0;
            r_state <= S_RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
          r_done <= 1'b0;
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_mm  <= w_mm_next;
          if (w_exit) begin
            // Result registers only move on DONE entry so they stay stable
            // through IDLE and the next RUN.
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_eq     <= w_acc_next;
            r_mm_idx <= w_mm_next;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = r_ready;
  assign busy   = r_busy;
  assign done   = r_done;
  assign eq     = r_eq;
  assign mm_idx = r_mm_idx;

endmodule

// File: tb/tb_eq_serial_ctrl.sv
module tb_eq_serial_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;

  logic       ready_e, busy_e, done_e, eq_e;
  logic [2:0] mm_e;
  logic       ready_f, busy_f, done_f, eq_f;
  logic [2:0] mm_f;

  int vectors;
  int miscompares;

  // Early-exit instance
  eq_serial_ctrl #(.W(8), .EARLY_EXIT(1)) dut_e (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .ready(ready_e), .busy(busy_e), .done(done_e), .eq(eq_e), .mm_idx(mm_e)
  );

  // Full-scan instance
  eq_serial_ctrl #(.W(8), .EARLY_EXIT(0)) dut_f (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .ready(ready_f), .busy(busy_f), .done(done_f), .eq(eq_f), .mm_idx(mm_f)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch a compare in cycle 0 and observe cycles 1..11, recording the first
  // done cycle, the result seen there, and the number of done pulses.
  task automatic run_capture(input logic [7:0] va, input logic [7:0] vb,
                             output int de, output int df,
                             output logic eqe, output logic eqf,
                             output logic [2:0] mme, output logic [2:0] mmf,
                             output int npe, output int npf);
    de = -1; df = -1; npe = 0; npf = 0;
    eqe = 1'bx; eqf = 1'bx; mme = 3'bxxx; mmf = 3'bxxx;
    a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (done_e === 1'b1) begin
        npe++;
        if (de < 0) begin de = c; eqe = eq_e; mme = mm_e; end
      end
      if (done_f === 1'b1) begin
        npf++;
        if (df < 0) begin df = c; eqf = eq_f; mmf = mm_f; end
      end
      if (c < 11) tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34;
    tick(); tick();
    vectors++;
    if ({ready_e, busy_e, done_e, eq_e, mm_e} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_e: got %b expected 1000000", {ready_e, busy_e, done_e, eq_e, mm_e});
    end
    vectors++;
    if ({ready_f, busy_f, done_f, eq_f, mm_f} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_f: got %b expected 1000000", {ready_f, busy_f, done_f, eq_f, mm_f});
    end
    start = 1'b0; reset = 1'b0;
    tick();
  endtask

  task automatic test_full_equal;
    a = 8'hA5; b = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      vectors++;
      if (busy_e !== ((c >= 1 && c <= 8) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL equal_busy c=%0d: got %b", c, busy_e);
      end
      vectors++;
      if (done_e !== ((c == 9) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL equal_done c=%0d: got %b", c, done_e);
      end
      vectors++;
      if (ready_e !== ((c == 10) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL equal_ready c=%0d: got %b", c, ready_e);
      end
      if (c == 9) begin
        vectors++;
        if ({eq_e, mm_e, done_f, eq_f, mm_f} !== 9'b1_000_1_1_000) begin
          miscompares++;
          $display("FAIL equal_result: got %b expected 100011000", {eq_e, mm_e, done_f, eq_f, mm_f});
        end
      end
      tick();
    end
  endtask

  task automatic test_early_exit;
    int de, df, npe, npf;
    logic eqe, eqf;
    logic [2:0] mme, mmf;
    run_capture(8'h10, 8'h00, de, df, eqe, eqf, mme, mmf, npe, npf);
    vectors++;
    if (de != 6 || npe != 1) begin
      miscompares++;
      $display("FAIL early_bit4_cycle: got done@%0d pulses %0d expected done@6 pulses 1", de, npe);
    end
    vectors++;
    if (eqe !== 1'b0 || mme !== 3'd4) begin
      miscompares++;
      $display("FAIL early_bit4_result: got eq=%b mm=%0d expected eq=0 mm=4", eqe, mme);
    end
    vectors++;
    if (df != 9 || eqf !== 1'b0 || mmf !== 3'd4) begin
      miscompares++;
      $display("FAIL full_bit4: got done@%0d eq=%b mm=%0d expected done@9 eq=0 mm=4", df, eqf, mmf);
    end
    run_capture(8'h01, 8'h00, de, df, eqe, eqf, mme, mmf, npe, npf);
    vectors++;
    if (de != 2 || npe != 1 || eqe !== 1'b0 || mme !== 3'd0) begin
      miscompares++;
      $display("FAIL early_bit0: got done@%0d pulses %0d eq=%b mm=%0d expected done@2 pulses 1 eq=0 mm=0", de, npe, eqe, mme);
    end
  endtask

  task automatic test_full_scan;
    int de, df, npe, npf;
    logic eqe, eqf;
    logic [2:0] mme, mmf;
    run_capture(8'h06, 8'h00, de, df, eqe, eqf, mme, mmf, npe, npf);
    vectors++;
    if (df != 9 || npf != 1 || eqf !== 1'b0 || mmf !== 3'd1) begin
      miscompares++;
      $display("FAIL full_first_kept: got done@%0d pulses %0d eq=%b mm=%0d expected done@9 pulses 1 eq=0 mm=1", df, npf, eqf, mmf);
    end
    vectors++;
    if (de != 3 || mme !== 3'd1) begin
      miscompares++;
      $display("FAIL early_bit1: got done@%0d mm=%0d expected done@3 mm=1", de, mme);
    end
    run_capture(8'h80, 8'h00, de, df, eqe, eqf, mme, mmf, npe, npf);
    vectors++;
    if (df != 9 || eqf !== 1'b0 || mmf !== 3'd7) begin
      miscompares++;
      $display("FAIL full_bit7: got done@%0d eq=%b mm=%0d expected done@9 eq=0 mm=7", df, eqf, mmf);
    end
    vectors++;
    if (de != 9 || eqe !== 1'b0 || mme !== 3'd7) begin
      miscompares++;
      $display("FAIL early_bit7: got done@%0d eq=%b mm=%0d expected done@9 eq=0 mm=7", de, eqe, mme);
    end
  endtask

  task automatic test_back_to_back;
    a = 8'h3C; b = 8'h3C; start = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      vectors++;
      if (ready_e !== (((c % 10) == 0) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL b2b_ready c=%0d: got %b", c, ready_e);
      end
      vectors++;
      if (done_f !== (((c % 10) == 9) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL b2b_done c=%0d: got %b", c, done_f);
      end
      if (c == 5) begin
        // Previous result (0x80 vs 0x00) must still be held mid-compare.
        vectors++;
        if ({busy_e, eq_e, mm_e} !== 5'b1_0_111) begin
          miscompares++;
          $display("FAIL b2b_hold: got %b expected 10111", {busy_e, eq_e, mm_e});
        end
      end
      if (c == 19) begin
        vectors++;
        if ({eq_e, mm_e} !== 4'b1000) begin
          miscompares++;
          $display("FAIL b2b_result: got %b expected 1000", {eq_e, mm_e});
        end
      end
      if (c < 30) tick();
    end
    tick();
    start = 1'b0;
    for (int c = 0; c < 10; c++) tick();
  endtask

  task automatic test_operand_change;
    a = 8'h5A; b = 8'h5A; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) begin a = 8'hFF; b = 8'h00; end
      if (c == 9) begin
        vectors++;
        if ({done_e, eq_e, mm_e, done_f, eq_f, mm_f} !== 10'b1_1_000_1_1_000) begin
          miscompares++;
          $display("FAIL operand_change: got %b expected 1100011000", {done_e, eq_e, mm_e, done_f, eq_f, mm_f});
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight;
    int de, df, npe, npf;
    logic eqe, eqf;
    logic [2:0] mme, mmf;
    a = 8'h77; b = 8'h77; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({ready_e, busy_e, done_e, eq_e, mm_e, ready_f, busy_f, done_f, eq_f, mm_f} !== 14'b1000000_1000000) begin
      miscompares++;
      $display("FAIL midflight_reset: got %b expected 10000001000000",
               {ready_e, busy_e, done_e, eq_e, mm_e, ready_f, busy_f, done_f, eq_f, mm_f});
    end
    run_capture(8'hC3, 8'hC3, de, df, eqe, eqf, mme, mmf, npe, npf);
    vectors++;
    if (de != 9 || npe != 1 || eqe !== 1'b1 || mme !== 3'd0) begin
      miscompares++;
      $display("FAIL after_reset_compare: got done@%0d pulses %0d eq=%b mm=%0d expected done@9 pulses 1 eq=1 mm=0", de, npe, eqe, mme);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_full_equal();
    test_early_exit();
    test_full_scan();
    test_back_to_back();
    test_operand_change();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
